uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared receiver FSM state type and default line parameters.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int DEFAULT_FREQ = 27000000;
  localparam int DEFAULT_BAUD = 115200;
  localparam int CNT_W        = 24;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous bit.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, mid-bit sampling, framing-error detection.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ = DEFAULT_FREQ,
  parameter int BAUD = DEFAULT_BAUD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] c_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_HALF_END = CNT_W'(HALF_BIT - 1);

  logic             w_rx_s;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             w_half_hit;
  logic             w_bit_hit;
  logic             w_sample;
  logic             w_load;
  logic             w_err;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_d   (uart_rx_i),
    .o_q   (w_rx_s)
  );

  assign w_half_hit = (r_cnt == c_HALF_END);
  assign w_bit_hit  = (r_cnt == c_BIT_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE:      if (!w_rx_s) w_state_nxt = START;
      START:     if (w_half_hit) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_bit_hit) begin
          w_sample = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_hit) begin
          if (w_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (w_rx_s) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change and at each data-bit boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_ferr  <= w_err;
      if ((w_state_nxt != r_state) || w_sample ||
          (r_state == IDLE) || (r_state == WAIT_HIGH))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == START)
        r_bit_idx <= 3'd0;
      else if (w_sample)
        r_bit_idx <= r_bit_idx + 3'd1;
      if (w_sample) r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_load)   r_data  <= r_shift;
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx (vector table, corner cases, random frames).
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int BIT = 234;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int both_hi = 0;
  logic [7:0] vq[$];
  int         vt[$];

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.FREQ(27000000), .BAUD(115200)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .uart_rx_i   (rx),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        n_valid++;
        vq.push_back(data);
        vt.push_back(cyc);
      end
      if (ferr) n_ferr++;
      if (valid && ferr) both_hi++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
    rx = 1'b0;
    wait_cyc(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(period);
    end
    rx = stop;
    wait_cyc(period);
    rx = 1'b1;
  endtask

  initial begin
    int         bv;
    int         bf;
    int         bq;
    logic [7:0] m_data;
    logic [7:0] rb;
    int         rp;
    logic       rs;

    vecs[0] = '{8'h55, 234, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h5A, 229, 1'b1, 1, 0, 8'h5A};
    vecs[2] = '{8'hC3, 239, 1'b1, 1, 0, 8'hC3};
    vecs[3] = '{8'h00, 234, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 234, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{8'h81, 234, 1'b0, 0, 1, 8'hFF};
    vecs[6] = '{8'h42, 234, 1'b1, 1, 0, 8'h42};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data",  int'(data),  0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_ferr",  int'(ferr),  0);
    chk("reset_busy",  int'(busy),  0);
    rst = 1'b0;
    wait_cyc(5);

    // Vector table
    for (int k = 0; k < 7; k++) begin
      bv = n_valid;
      bf = n_ferr;
      send_frame(vecs[k].data, vecs[k].period, vecs[k].stop);
      wait_cyc(300);
      chk($sformatf("vec%0d_valid", k), n_valid - bv, vecs[k].exp_valid);
      chk($sformatf("vec%0d_ferr", k),  n_ferr - bf,  vecs[k].exp_ferr);
      chk($sformatf("vec%0d_data", k),  int'(data),   int'(vecs[k].exp_data));
    end
    m_data = 8'h42;

    // Back-to-back frames with no idle gap
    bv = n_valid;
    bq = vq.size();
    send_frame(8'hA5, BIT, 1'b1);
    send_frame(8'h3C, BIT, 1'b1);
    wait_cyc(300);
    chk("b2b_count", n_valid - bv, 2);
    if (vq.size() >= bq + 2) begin
      chk("b2b_first",   int'(vq[bq]),     8'hA5);
      chk("b2b_second",  int'(vq[bq + 1]), 8'h3C);
      chk("b2b_spacing", vt[bq + 1] - vt[bq], 2340);
    end
    m_data = 8'h3C;

    // 50-cycle glitch on the line
    bv = n_valid;
    bf = n_ferr;
    rx = 1'b0;
    wait_cyc(50);
    rx = 1'b1;
    wait_cyc(10);
    chk("glitch_busy_mid", int'(busy), 1);
    wait_cyc(60);
    chk("glitch_busy_end", int'(busy), 0);
    wait_cyc(200);
    chk("glitch_valid", n_valid - bv, 0);
    chk("glitch_ferr",  n_ferr - bf,  0);

    // Framing error followed by a long break
    bv = n_valid;
    bf = n_ferr;
    send_frame(8'h81, BIT, 1'b0);
    rx = 1'b0;
    wait_cyc(5000);
    chk("break_ferr",  n_ferr - bf,  1);
    chk("break_valid", n_valid - bv, 0);
    chk("break_data",  int'(data), int'(m_data));
    rx = 1'b1;
    wait_cyc(300);
    bv = n_valid;
    send_frame(8'h42, BIT, 1'b1);
    wait_cyc(300);
    chk("after_break_valid", n_valid - bv, 1);
    chk("after_break_data",  int'(data), 8'h42);

    // Reset during data bit 4 of 0xFF
    bv = n_valid;
    bf = n_ferr;
    rx = 1'b0;
    wait_cyc(BIT);
    rx = 1'b1;
    wait_cyc(4 * BIT + 100);
    chk("rst_mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_data", int'(data), 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1500);
    chk("rst_mid_valid", n_valid - bv, 0);
    chk("rst_mid_ferr",  n_ferr - bf,  0);
    bv = n_valid;
    send_frame(8'h0F, BIT, 1'b1);
    wait_cyc(300);
    chk("after_rst_valid", n_valid - bv, 1);
    chk("after_rst_data",  int'(data), 8'h0F);
    m_data = 8'h0F;

    // Random frames against the reference model
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      rp = $urandom_range(229, 239);
      rs = ($urandom_range(0, 3) != 0);
      bv = n_valid;
      bf = n_ferr;
      send_frame(rb, rp, rs);
      wait_cyc(300);
      if (rs) m_data = rb;
      chk($sformatf("rand%0d_valid", k), n_valid - bv, rs ? 1 : 0);
      chk($sformatf("rand%0d_ferr", k),  n_ferr - bf,  rs ? 0 : 1);
      chk($sformatf("rand%0d_data", k),  int'(data),   int'(m_data));
    end

    chk("valid_ferr_exclusive", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
